// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Next-PC unit. Owns the PC register, resolves J/JAL/JR and the
//             conditional branches from register operands, and keeps a
//             circular return-address stack that scores JR targets.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                RAS_DEPTH = 4,
    parameter int                CNT_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rt_field,
    input  logic [5:0]        func,
    input  logic [25:0]       target26,
    input  logic [15:0]       imm16,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic [ADDR_W-1:0] rt_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              link_we,
    output logic              taken,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_hit,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int c_PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_CNT_RAS_W = $clog2(RAS_DEPTH + 1);
    localparam logic [c_PTR_W-1:0]     c_PTR_LAST   = c_PTR_W'(RAS_DEPTH - 1);
    localparam logic [c_CNT_RAS_W-1:0] c_COUNT_FULL = c_CNT_RAS_W'(RAS_DEPTH);

    logic [ADDR_W-1:0]      r_pc;
    logic [ADDR_W-1:0]      r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0]     r_ptr;
    logic [c_CNT_RAS_W-1:0] r_count;
    logic [CNT_W-1:0]       r_miss;

    logic [ADDR_W-1:0]  w_p4;
    logic [ADDR_W-1:0]  w_boff;
    logic [ADDR_W-1:0]  w_btarget;
    logic [ADDR_W-1:0]  w_jtarget;
    logic [ADDR_W-1:0]  w_next_pc;
    logic               w_taken;
    logic               w_is_j;
    logic               w_is_jal;
    logic               w_is_jr;
    logic               w_is_beq;
    logic               w_is_bne;
    logic               w_is_bgez;
    logic               w_is_bltz;
    logic [c_PTR_W-1:0] w_top_idx;
    logic [c_PTR_W-1:0] w_ptr_inc;
    logic               w_empty;
    logic               w_full;
    logic               w_hit;

    // Instruction decode
    assign w_is_j    = (opcode == 6'b000010);
    assign w_is_jal  = (opcode == 6'b000011);
    assign w_is_jr   = (opcode == 6'b000000) && (func == 6'b001000);
    assign w_is_beq  = (opcode == 6'b000100);
    assign w_is_bne  = (opcode == 6'b000101);
    assign w_is_bgez = (opcode == 6'b000001) && (rt_field == 5'b00001);
    assign w_is_bltz = (opcode == 6'b000001) && (rt_field == 5'b00000);

    // Sequential and branch targets; the word offset is sign-extended then scaled by 4
    assign w_p4      = r_pc + ADDR_W'(4);
    assign w_boff    = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    assign w_btarget = w_p4 + w_boff;

    // Jump target keeps the upper PC region bits only when the PC is wider than 28 bits
    generate
        if (ADDR_W == 28) begin : g_jt_narrow
            assign w_jtarget = {target26, 2'b00};
        end else begin : g_jt_wide
            assign w_jtarget = {w_p4[ADDR_W-1:28], target26, 2'b00};
        end
    endgenerate

    // RAS status: top sits one slot behind the write pointer
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_COUNT_FULL);
    assign w_top_idx = (r_ptr == '0) ? c_PTR_LAST : r_ptr - c_PTR_W'(1);
    assign w_ptr_inc = (r_ptr == c_PTR_LAST) ? '0 : r_ptr + c_PTR_W'(1);
    assign w_hit     = w_is_jr && !w_empty && (r_ras[w_top_idx] == rs_data);

    // Next-PC selection; anything undecoded falls through to pc+4
    always_comb begin
        w_next_pc = w_p4;
        w_taken   = 1'b0;
        if (w_is_j || w_is_jal) begin
            w_next_pc = w_jtarget;
            w_taken   = 1'b1;
        end else if (w_is_jr) begin
            w_next_pc = rs_data;
            w_taken   = 1'b1;
        end else if ((w_is_beq  && (rs_data == rt_data)) ||
                     (w_is_bne  && (rs_data != rt_data)) ||
                     (w_is_bgez && !rs_data[ADDR_W-1])   ||
                     (w_is_bltz &&  rs_data[ADDR_W-1])) begin
            w_next_pc = w_btarget;
            w_taken   = 1'b1;
        end
    end

    // PC register advances whenever the pipeline is not stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (!stall) begin
            r_pc <= w_next_pc;
        end
    end

    // Return-address stack: JAL pushes (overwriting oldest when full), JR pops if non-empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (!stall) begin
            if (w_is_jal) begin
                r_ras[r_ptr] <= w_p4;
                r_ptr        <= w_ptr_inc;
                if (!w_full) begin
                    r_count <= r_count + c_CNT_RAS_W'(1);
                end
            end else if (w_is_jr && !w_empty) begin
                r_ptr   <= w_top_idx;
                r_count <= r_count - c_CNT_RAS_W'(1);
            end
        end
    end

    // Saturating count of JRs whose target disagreed with the RAS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_miss <= '0;
        end else if (!stall && w_is_jr && !w_hit && (r_miss != '1)) begin
            r_miss <= r_miss + CNT_W'(1);
        end
    end

    assign pc        = r_pc;
    assign link_addr = w_p4;
    assign link_we   = w_is_jal && !stall;
    assign taken     = w_taken;
    assign ras_top   = w_empty ? '0 : r_ras[w_top_idx];
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_hit   = w_hit;
    assign miss_cnt  = r_miss;

endmodule
`default_nettype wire
